sprite_animator: RTL
====================

# sprite_animator

Parametrised, animated sprite fetch engine for the VGA pipeline. It maps the current beam position (DrawX, DrawY) onto a positioned, integer-scaled, optionally mirrored sprite drawn from a multi-frame ROM, and advances the animation frame on frame boundaries. It outputs a palette index plus an opaque-hit flag for the downstream compositor and palette stage, replacing the fixed full-screen stretched sprite renderers.

## Interface
Parameters:
- SPR_W, 70, sprite frame width in pixels
- SPR_H, 81, sprite frame height in pixels
- FRAMES, 4, number of animation frames stored back-to-back in ROM
- FRAME_TICKS, 6, video frames each animation frame is held (≥1)
- ADDR_W, 15, ROM address width; must hold FRAMES*SPR_W*SPR_H-1
- IDX_W, 4, palette index width
- TRANSPARENT_IDX, 0, index treated as transparent

Ports:
- vga_clk  in  1  pixel clock; all logic on posedge
- reset  in  1  asynchronous, active-high
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = active video region
- frame_start  in  1  one-cycle pulse once per video frame, during vertical blank
- sprite_x  in  10  requested left edge, screen coordinates
- sprite_y  in  10  requested top edge, screen coordinates
- scale  in  2  0 = 1x, 1 = 2x, 2 = 4x, 3 = 4x
- flip  in  1  1 = mirror horizontally
- anim_en  in  1  1 = animation advances
- play_once  in  1  1 = stop on last frame; 0 = loop
- restart  in  1  one-cycle pulse: return to frame 0
- rom_address  out  ADDR_W  registered address to the synchronous sprite ROM
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_address
- pal_index  out  IDX_W  palette index for the pixel
- hit  out  1  pixel is inside the sprite, opaque, and in active video
- frame_idx  out  clog2(FRAMES)  currently displayed animation frame
- done  out  1  play_once sequence has reached its last frame

## Operation
- Shadow registers for sprite_x, sprite_y, scale, and flip load only on frame_start, so geometry never tears mid-frame. They reset to 0.
- Local coordinates:
  - dx = DrawX − sx_shadow; dy = DrawY − sy_shadow, computed 11-bit signed.
  - lx = dx >> s and ly = dy >> s, where s = min(scale_shadow, 2).
- In-bounds requires dx ≥ 0, dy ≥ 0, lx < SPR_W, and ly < SPR_H. Out-of-bounds pixels never produce a hit, including pixels past screen edge 639/479.
- Mirroring: cx = flip_shadow ? SPR_W−1−lx : lx.
- Address: rom_address = frame_idx*SPR_W*SPR_H + ly*SPR_W + cx, truncated to ADDR_W. When out of bounds, rom_address holds the frame base.
- Animation:
  - tick counter (0..FRAME_TICKS−1) increments on frame_start when anim_en = 1.
  - On a frame_start that finds tick = FRAME_TICKS−1, tick clears and the frame advances.
  - Loop mode: FRAMES−1 → 0.
  - play_once: frame holds at FRAMES−1, done sets, and the counters freeze.
  - anim_en = 0 holds tick and frame.
  - frame_idx changes only on a frame_start cycle.
- restart clears tick, frame_idx, and done on the next edge. If restart and frame_start arrive on the same cycle, restart wins for the animation state. Shadow geometry still loads on that cycle.
- Toggling play_once from 1 to 0 while done = 1 clears done. Looping resumes at the next advance.
- hit = inbounds_d & blank_d & (rom_q ≠ TRANSPARENT_IDX), where inbounds_d and blank_d are delayed to align with rom_q.
- pal_index = rom_q when hit, otherwise 0.

## Timing
- Stage 1 (edge N+1): registers rom_address, inbounds, and blank from the DrawX/DrawY presented in cycle N.
- ROM: returns rom_q during cycle N+1.
- Stage 2 (edge N+2): registers pal_index and hit. Total latency is 2 vga_clk cycles, fixed.
- Throughput: one pixel per clock, no stalls.
- Reset state: all outputs are 0, counters are 0, and shadows are 0. Reset is asynchronous on assertion and released synchronously by the surrounding reset logic.
- Reset mid-frame: the pipeline flushes. hit stays 0 until two valid cycles after release.
- The frame_idx used for addressing updates on the same edge as the shadow registers.

## Test plan
- Geometry:
  - Stimulus: shadow loaded with sprite_x = 100, sprite_y = 50, scale = 0, flip = 0; drive DrawX = 100, DrawY = 50.
  - Response: rom_address = 0 after 1 cycle; pal_index and hit follow after 2 cycles.
  - Stimulus: DrawX = 169, then 170.
  - Response: address 69, then hit = 0 at 170.
- Scale and flip:
  - Stimulus: scale = 1, flip = 1, DrawX = 100, DrawY = 52.
  - Response: rom_address = 1*70 + 69 = 139.
  - Stimulus: scale = 3.
  - Response: behaves identically to scale = 2.
- Transparency and blank:
  - Stimulus: rom_q = TRANSPARENT_IDX.
  - Response: hit = 0 and pal_index = 0.
  - Stimulus: blank = 0 with an opaque in-bounds pixel.
  - Response: hit = 0.
- Animation loop:
  - Stimulus: FRAME_TICKS = 6, anim_en = 1, 24 frame_start pulses.
  - Response: frame_idx steps 0→1→2→3→0 after pulses 6, 12, 18, 24.
  - Stimulus: anim_en = 0.
  - Response: frame_idx holds.
- play_once and restart:
  - Stimulus: play_once = 1 and enough pulses to reach the last frame.
  - Response: frame_idx reaches 3, done = 1, and frame_idx holds 3 through 12 further pulses.
  - Stimulus: restart and frame_start on the same cycle.
  - Response: frame_idx = 0, done = 0, tick = 0.
- Reset and tearing:
  - Stimulus: assert reset mid-line.
  - Response: all outputs are 0 immediately.
  - Stimulus: change sprite_x mid-frame.
  - Response: no effect until the next frame_start.

Source files
------------

// File: rtl/sprite_animator.sv
// Animated sprite fetch engine: maps the beam position onto a positioned, scaled,
// optionally mirrored sprite frame in ROM and returns a palette index plus opaque hit.
module sprite_animator #(
  parameter int SPR_W = 70,
  parameter int SPR_H = 81,
  parameter int FRAMES = 4,
  parameter int FRAME_TICKS = 6,
  parameter int ADDR_W = 15,
  parameter int IDX_W = 4,
  parameter logic [IDX_W-1:0] TRANSPARENT_IDX = {IDX_W{1'b0}},
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_start,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic [1:0]        scale,
  input  logic              flip,
  input  logic              anim_en,
  input  logic              play_once,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  output logic              hit,
  output logic [FW-1:0]     frame_idx,
  output logic              done
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int FRAME_SZ = SPR_W * SPR_H;

  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [1:0]        scale_q, scale_d;
  logic              flip_q, flip_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inb_q, inb_d, blank_q, blank_d;
  logic [IDX_W-1:0]  pal_q, pal_d;
  logic              hit_q, hit_d;

  logic [10:0]       dx_s, dy_s, lx_s, ly_s, cx_s;
  logic [1:0]        sh_s;
  logic [ADDR_W-1:0] base_s;
  logic              last_tick_s, last_frame_s;

  // Shadow geometry: sampled only at frame_start so a frame never tears
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    scale_d = scale_q;
    flip_d  = flip_q;
    if (frame_start) begin
      sx_d    = sprite_x;
      sy_d    = sprite_y;
      scale_d = scale;
      flip_d  = flip;
    end else begin
      sx_d    = sx_q;
    end
  end

  // Stage 1: local coordinates, bounds test and ROM address
  always_comb begin
    dx_s   = {1'b0, DrawX} - {1'b0, sx_q};
    dy_s   = {1'b0, DrawY} - {1'b0, sy_q};
    sh_s   = (scale_q == 2'd3) ? 2'd2 : scale_q;
    lx_s   = dx_s >> sh_s;
    ly_s   = dy_s >> sh_s;
    cx_s   = flip_q ? (11'(SPR_W - 1) - lx_s) : lx_s;
    inb_d  = ~dx_s[10] & ~dy_s[10] & (lx_s < 11'(SPR_W)) & (ly_s < 11'(SPR_H));
    base_s = ADDR_W'(frame_q) * ADDR_W'(FRAME_SZ);
    if (inb_d) begin
      addr_d = base_s + ADDR_W'(ly_s) * ADDR_W'(SPR_W) + ADDR_W'(cx_s);
    end else begin
      addr_d = base_s;
    end
    blank_d = blank;
  end

  // Stage 2: opacity and active-video qualification of the ROM data
  always_comb begin
    hit_d = inb_q & blank_q & (rom_q != TRANSPARENT_IDX);
    if (hit_d) begin
      pal_d = rom_q;
    end else begin
      pal_d = {IDX_W{1'b0}};
    end
  end

  // Animation: restart dominates; a finished play_once sequence freezes the counters
  always_comb begin
    tick_d       = tick_q;
    frame_d      = frame_q;
    done_d       = done_q;
    last_tick_s  = (tick_q == TW'(FRAME_TICKS - 1));
    last_frame_s = (frame_q == FW'(FRAMES - 1));
    if (restart) begin
      tick_d  = {TW{1'b0}};
      frame_d = {FW{1'b0}};
      done_d  = 1'b0;
    end else if (done_q) begin
      if (!play_once) begin
        done_d = 1'b0;
      end else begin
        done_d = 1'b1;
      end
    end else if (frame_start && anim_en) begin
      if (last_tick_s) begin
        tick_d = {TW{1'b0}};
        if (last_frame_s) begin
          if (play_once) begin
            done_d = 1'b1;
          end else begin
            frame_d = {FW{1'b0}};
          end
        end else begin
          frame_d = frame_q + FW'(1);
          if (play_once && (frame_q == FW'(FRAMES - 2))) begin
            done_d = 1'b1;
          end else begin
            done_d = 1'b0;
          end
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end else begin
      tick_d = tick_q;
    end
  end

  // State and pipeline registers
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      sx_q    <= 10'd0;
      sy_q    <= 10'd0;
      scale_q <= 2'd0;
      flip_q  <= 1'b0;
      tick_q  <= {TW{1'b0}};
      frame_q <= {FW{1'b0}};
      done_q  <= 1'b0;
      addr_q  <= {ADDR_W{1'b0}};
      inb_q   <= 1'b0;
      blank_q <= 1'b0;
      pal_q   <= {IDX_W{1'b0}};
      hit_q   <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      scale_q <= scale_d;
      flip_q  <= flip_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      inb_q   <= inb_d;
      blank_q <= blank_d;
      pal_q   <= pal_d;
      hit_q   <= hit_d;
    end
  end

  assign rom_address = addr_q;
  assign pal_index   = pal_q;
  assign hit         = hit_q;
  assign frame_idx   = frame_q;
  assign done        = done_q;

endmodule
